au_in_fifo: RTL and testbench
=============================

AU_IN_FIFO -- requirements
Module: au_in_fifo

Interface
REQ-001 Parameter DATA_W, default 16: sample width per channel, 8..32.
REQ-002 Parameter CHANNELS, default 2: channels per frame, 1..8.
REQ-003 Parameter DEPTH, default 64: FIFO depth in frames, a power of two, 2..1024.
REQ-004 Parameter SIGNED, default 1: 1 = sign-extend samples to 32 bits, 0 = zero-extend.
REQ-005 clk  in  1  single clock; all logic rises on its posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_port  in  CHANNELS*DATA_W  frame; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 sample_strobe  in  1  frame-ready strobe, synchronous to clk.
REQ-009 address  in  2  Avalon-MM word address.
REQ-010 read  in  1  Avalon-MM read request.
REQ-011 write  in  1  Avalon-MM write request.
REQ-012 writedata  in  32  write data.
REQ-013 readdata  out  32  registered read data.
REQ-014 irq  out  1  level interrupt, registered.

Function
REQ-015 Capture SHALL occur on a 0->1 transition of sample_strobe, detected against a 1-cycle delayed copy; a held-high strobe pushes once.
REQ-016 When CONTROL.en=0, edges SHALL be ignored, and the edge detector SHALL keep tracking.
REQ-017 A capture SHALL latch the in_port value of the edge cycle as one FIFO frame.
REQ-018 Capture while full and with no same-cycle pop SHALL drop the frame and set STATUS.ovf (sticky).
REQ-019 Capture and pop in the same cycle SHALL both succeed; level stays unchanged; no overflow, even when full.
REQ-020 Register map: 0 DATA (R), 1 STATUS (R), 2 CONTROL (R/W), 3 COMMAND (W; reads return 0).
REQ-021 readdata SHALL be registered: the value for a read in cycle N appears in cycle N+1; readdata holds otherwise.
REQ-022 DATA read when not empty SHALL return channel ch_idx of the head frame, sign- or zero-extended per SIGNED, then ch_idx <= ch_idx+1.
REQ-023 A DATA read of channel CHANNELS-1 SHALL pop the head frame and reset ch_idx to 0.
REQ-024 DATA read when empty SHALL return 0 and change no state.
REQ-025 STATUS bits: [10:0] level in frames; [16] empty; [17] full; [18] ovf; [19] irq; [22:20] ch_idx; others 0.
REQ-026 CONTROL bits: [0] en; [1] irq_en; [26:16] threshold in frames; others read 0.
REQ-027 COMMAND write bit0=1 SHALL clear ovf; bit1=1 SHALL flush (pointers, level and ch_idx to 0; FIFO contents don't-care).
REQ-028 Flush and capture in the same cycle: flush wins; the frame is discarded.
REQ-029 Clear-ovf and overflow in the same cycle: ovf SHALL end set.
REQ-030 irq (next cycle) = irq_en AND ((threshold != 0 AND level >= threshold) OR ovf).
REQ-031 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH, with full = (level == DEPTH).
REQ-032 Simultaneous read and write SHALL both take effect.

Reset
REQ-033 While reset is high: readdata=0, irq=0, level=0, pointers=0, ch_idx=0, ovf=0, en=0, irq_en=0, threshold=0, edge-detector delay register=0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered frames immediately, without waiting for a clock edge.
REQ-035 The first strobe edge SHALL be recognised no earlier than the cycle after reset deasserts.

Verification
REQ-036 DATA_W=16, CHANNELS=2, SIGNED=1, en=1; in_port=0x8000_1234, one strobe pulse -> DATA reads return 0x00001234, then 0xFFFF8000; STATUS.level goes 1 -> 0.
REQ-037 DEPTH=4, en=1; 5 strobe edges with no reads -> level=4, full=1, ovf=1; the 4 frames read back in order; write COMMAND=1 -> ovf=0.
REQ-038 Strobe held high 10 cycles -> exactly one frame captured; en=0 plus a strobe edge -> level unchanged.
REQ-039 FIFO full, and a channel-1 DATA read coincides with a strobe edge -> level stays 4, ovf stays 0, new frame at the tail.
REQ-040 irq_en=1, threshold=3; 3 frames pushed -> irq=1 in the cycle after the 3rd push; one full frame read -> irq=0.
REQ-041 Flush (COMMAND=2) coincident with a strobe edge -> level=0, empty=1, a DATA read returns 0; reset pulse mid-stream -> all registers at their REQ-033 values.

Source files
------------

// File: rtl/au_in_fifo.sv
// rtl/au_in_fifo.sv - multi-channel audio sample capture FIFO with Avalon-MM register access
module au_in_fifo #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 64,
    parameter int SIGNED   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*DATA_W-1:0]   in_port,
    input  logic                         sample_strobe,
    input  logic [1:0]                   address,
    input  logic                         read,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          FW      = CHANNELS * DATA_W;
    localparam logic [10:0] DEPTH_L = 11'(DEPTH);
    localparam logic [2:0]  LAST_CH = 3'(CHANNELS - 1);

    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [10:0]    level;
    logic [2:0]     ch_idx;
    logic           strobe_d;
    logic           ovf;
    logic           en;
    logic           irq_en;
    logic [10:0]    threshold;

    logic           strobe_edge;
    logic           empty;
    logic           full;
    logic           data_rd;
    logic           pop;
    logic           cmd_wr;
    logic           flush;
    logic           clr_ovf;
    logic           capture;
    logic           push;
    logic           overflow;
    logic [FW-1:0]  head;
    logic [DATA_W-1:0] sample;
    logic [31:0]    sample_ext;
    logic [31:0]    status_word;
    logic [31:0]    control_word;
    logic [31:0]    rd_mux;
    logic           unused_bits;

    assign unused_bits = ^{writedata[31:27], writedata[15:2]};

    assign strobe_edge = sample_strobe & ~strobe_d;
    assign empty       = (level == 11'd0);
    assign full        = (level == DEPTH_L);
    assign data_rd     = read && (address == 2'd0) && !empty;
    assign pop         = data_rd && (ch_idx == LAST_CH);
    assign cmd_wr      = write && (address == 2'd3);
    assign flush       = cmd_wr & writedata[1];
    assign clr_ovf     = cmd_wr & writedata[0];
    // Flush discards a coincident capture; a pop in the same cycle frees a slot even when full.
    assign capture     = strobe_edge & en & ~flush;
    assign push        = capture & (~full | pop);
    assign overflow    = capture & full & ~pop;

    assign head = mem[rd_ptr];

    always_comb begin
        sample = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_idx == 3'(k)) begin
                sample = head[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        sample_ext = ((SIGNED != 0) && sample[DATA_W-1]) ? 32'hFFFF_FFFF : 32'h0;
        sample_ext[DATA_W-1:0] = sample;
    end

    assign status_word  = {9'b0, ch_idx, irq, ovf, full, empty, 5'b0, level};
    assign control_word = {5'b0, threshold, 14'b0, irq_en, en};

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            2'd0:    rd_mux = empty ? 32'h0 : sample_ext;
            2'd1:    rd_mux = status_word;
            2'd2:    rd_mux = control_word;
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata  <= 32'h0;
            irq       <= 1'b0;
            strobe_d  <= 1'b0;
            ovf       <= 1'b0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= 11'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= 11'd0;
            ch_idx    <= 3'd0;
        end else begin
            strobe_d <= sample_strobe;
            if (read) begin
                readdata <= rd_mux;
            end
            irq <= irq_en & (((threshold != 11'd0) & (level >= threshold)) | ovf);

            if (write && (address == 2'd2)) begin
                en        <= writedata[0];
                irq_en    <= writedata[1];
                threshold <= writedata[26:16];
            end

            // Set has priority so an overflow coincident with a clear is not lost.
            if (overflow) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= 11'd0;
                ch_idx <= 3'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (data_rd) begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        ch_idx <= 3'd0;
                    end else begin
                        ch_idx <= ch_idx + 3'd1;
                    end
                end
                case ({push, pop})
                    2'b10:   level <= level + 11'd1;
                    2'b01:   level <= level - 11'd1;
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_port;
        end
    end

endmodule

// File: tb/tb_au_in_fifo.sv
// tb/tb_au_in_fifo.sv - randomized and directed check of au_in_fifo against a queue-based model
module tb_au_in_fifo;

    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = 32'h0;
    logic        strb = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wd = 32'h0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic [31:0] frame_q[$];
    logic        m_prev;
    int          m_ch;
    logic        m_ovf;
    logic        m_en;
    logic        m_irq_en;
    int          m_thr;
    logic [31:0] exp_rd;
    logic        exp_irq;

    au_in_fifo #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DEPTH), .SIGNED(1)) dut (
        .clk(clk), .reset(reset), .in_port(din), .sample_strobe(strb),
        .address(addr), .read(rd), .write(wr), .writedata(wd),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_prev = 1'b0; m_ch = 0; m_ovf = 1'b0; m_en = 1'b0;
        m_irq_en = 1'b0; m_thr = 0; exp_rd = 32'h0; exp_irq = 1'b0;
    endtask

    task automatic model_step();
        logic        edge_seen, ovfl, flush, clr, nxt_irq;
        int          lvl;
        logic [15:0] s;
        edge_seen = strb && !m_prev;
        m_prev    = strb;
        lvl       = frame_q.size();
        ovfl      = 1'b0;
        nxt_irq   = m_irq_en && ((m_thr != 0 && lvl >= m_thr) || m_ovf);
        if (rd) begin
            case (addr)
                2'd0: begin
                    if (lvl > 0) begin
                        s = 16'(frame_q[0] >> (DW * m_ch));
                        exp_rd = 32'($signed(s));
                    end else begin
                        exp_rd = 32'h0;
                    end
                end
                2'd1: exp_rd = 32'(lvl) | (32'(lvl == 0) << 16) | (32'(lvl == DEPTH) << 17)
                             | (32'(m_ovf) << 18) | (32'(exp_irq) << 19) | (32'(m_ch) << 20);
                2'd2: exp_rd = 32'(m_en) | (32'(m_irq_en) << 1) | (32'(m_thr) << 16);
                default: exp_rd = 32'h0;
            endcase
        end
        flush = wr && addr == 2'd3 && wd[1];
        clr   = wr && addr == 2'd3 && wd[0];
        if (flush) begin
            frame_q.delete();
            m_ch = 0;
        end else begin
            if (rd && addr == 2'd0 && lvl > 0) begin
                if (m_ch == CH - 1) begin
                    void'(frame_q.pop_front());
                    m_ch = 0;
                end else begin
                    m_ch++;
                end
            end
            if (edge_seen && m_en) begin
                if (frame_q.size() < DEPTH) frame_q.push_back(din);
                else ovfl = 1'b1;
            end
        end
        if (clr) m_ovf = 1'b0;
        if (ovfl) m_ovf = 1'b1;
        if (wr && addr == 2'd2) begin
            m_en = wd[0]; m_irq_en = wd[1]; m_thr = int'(wd[26:16]);
        end
        exp_irq = nxt_irq;
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        chk("readdata", readdata, exp_rd);
        chk("irq", {31'b0, irq}, {31'b0, exp_irq});
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic rreg(input logic [1:0] a);
        addr = a; rd = 1'b1; tick();
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        addr = a; wr = 1'b1; wd = d; tick();
    endtask

    task automatic pulse(input logic [31:0] d);
        din = d; strb = 1'b1; tick();
        strb = 1'b0; tick();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // signed two-channel frame
        wreg(2'd2, 32'h1);
        pulse(32'h8000_1234);
        rreg(2'd1); chk("lvl_one", readdata, 32'h0000_0001);
        rreg(2'd0); chk("ch0_data", readdata, 32'h0000_1234);
        rreg(2'd0); chk("ch1_data", readdata, 32'hFFFF_8000);
        rreg(2'd1); chk("lvl_zero", readdata, 32'h0001_0000);

        // overflow on fifth frame, then in-order readback and ovf clear
        for (int i = 0; i < 5; i++) pulse(32'h1111_0000 * (i + 1) + i);
        rreg(2'd1); chk("full_ovf", readdata, 32'h0006_0004);
        for (int i = 0; i < 2 * DEPTH; i++) rreg(2'd0);
        wreg(2'd3, 32'h1);
        rreg(2'd1); chk("ovf_clear", readdata, 32'h0001_0000);

        // held strobe captures once; disabled capture ignores edges
        din = 32'h0BAD_F00D; strb = 1'b1;
        repeat (10) tick();
        strb = 1'b0; tick();
        rreg(2'd1); chk("held_once", readdata, 32'h0000_0001);
        wreg(2'd2, 32'h0);
        pulse(32'h5555_AAAA);
        rreg(2'd1); chk("disabled", readdata, 32'h0000_0001);
        wreg(2'd3, 32'h2);

        // pop and capture together while full
        wreg(2'd2, 32'h1);
        for (int i = 0; i < DEPTH; i++) pulse(32'hA000_0000 + i);
        rreg(2'd0);
        din = 32'h7FFF_FFFF; strb = 1'b1; addr = 2'd0; rd = 1'b1; tick();
        strb = 1'b0; tick();
        rreg(2'd1); chk("full_pop_push", readdata, 32'h0002_0004);
        for (int i = 0; i < 2 * DEPTH; i++) rreg(2'd0);
        chk("tail_frame", readdata, 32'h0000_7FFF);

        // threshold interrupt
        wreg(2'd3, 32'h2);
        wreg(2'd2, 32'h0003_0003);
        for (int i = 0; i < 3; i++) pulse(32'hC0DE_0000 + i);
        chk("irq_thr", {31'b0, irq}, 32'h1);
        rreg(2'd0); rreg(2'd0); tick();
        chk("irq_low", {31'b0, irq}, 32'h0);

        // flush beats a coincident capture
        wreg(2'd2, 32'h1);
        pulse(32'h1); pulse(32'h2);
        din = 32'h3; strb = 1'b1; addr = 2'd3; wr = 1'b1; wd = 32'h2; tick();
        strb = 1'b0; tick();
        rreg(2'd1); chk("flush_status", readdata, 32'h0001_0000);
        rreg(2'd0); chk("flush_data", readdata, 32'h0);

        // randomized traffic
        repeat (800) begin
            din  = $urandom;
            strb = ($urandom_range(0, 1) == 1);
            addr = 2'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 2) != 0);
            wr   = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                wr = 1'b1;
                addr = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3;
                if (addr == 2'd2) wd = {5'b0, 11'($urandom_range(0, 5)), 14'b0, 1'($urandom), ($urandom_range(0, 4) != 0)};
                else wd = {30'b0, ($urandom_range(0, 3) == 0), 1'($urandom)};
            end
            tick();
        end

        // asynchronous reset mid-stream
        wreg(2'd2, 32'h0003_0003);
        pulse(32'h1234_5678);
        rreg(2'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rd", readdata, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        rreg(2'd1); chk("rst_status", readdata, 32'h0001_0000);
        rreg(2'd2); chk("rst_control", readdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
